// File: rtl/cache_bus_arbiter.sv
// Two-requester round-robin arbiter sharing one line-wide memory bus between
// the instruction cache (requester 0) and data cache (requester 1).
module cache_bus_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 64,
    parameter int unsigned LINE_WIDTH     = 1024,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  r0_valid,
    input  logic                  r0_store,
    input  logic [ADDR_WIDTH-1:0] r0_addr,
    input  logic [LINE_WIDTH-1:0] r0_wdata,
    output logic                  r0_bus_valid,
    output logic                  r0_bus_ready,
    output logic [LINE_WIDTH-1:0] r0_rdata,
    input  logic                  r1_valid,
    input  logic                  r1_store,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    input  logic [LINE_WIDTH-1:0] r1_wdata,
    output logic                  r1_bus_valid,
    output logic                  r1_bus_ready,
    output logic [LINE_WIDTH-1:0] r1_rdata,
    output logic                  mem_valid,
    output logic                  mem_store,
    output logic                  mem_rready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic                  mem_rvalid,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    input  logic                  mem_wready,
    output logic                  timeout_err
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_t                state, state_next;
    logic                  gnt_q;
    logic                  store_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LINE_WIDTH-1:0] wdata_q;
    logic                  rr_ptr;
    logic [CNT_W-1:0]      wd_cnt;

    logic any_req;
    logic pick;
    logic done;
    logic timeout_hit;

    assign any_req = r0_valid | r1_valid;
    // Contention goes to rr_ptr; otherwise the lone requester wins.
    assign pick    = (r0_valid & r1_valid) ? rr_ptr : r1_valid;
    // Only the handshake matching the latched direction completes the transfer.
    assign done    = (state == BUSY) && (store_q ? mem_wready : mem_rvalid);
    // Hit on the last allowed BUSY cycle, so the abort lands after exactly TIMEOUT_CYCLES.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (state == BUSY) && !done &&
                         (32'(wd_cnt) == TIMEOUT_CYCLES - 1);

    assign r0_rdata = mem_rdata;
    assign r1_rdata = mem_rdata;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_req) state_next = BUSY;
            BUSY:    if (done || timeout_hit) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_valid    = 1'b0;
        mem_store    = 1'b0;
        mem_rready   = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        r0_bus_valid = 1'b0;
        r0_bus_ready = 1'b0;
        r1_bus_valid = 1'b0;
        r1_bus_ready = 1'b0;
        if (state == BUSY) begin
            mem_valid    = 1'b1;
            mem_store    = store_q;
            mem_rready   = !store_q;
            mem_addr     = addr_q;
            mem_wdata    = wdata_q;
            r0_bus_valid = done && !gnt_q && !store_q;
            r0_bus_ready = done && !gnt_q &&  store_q;
            r1_bus_valid = done &&  gnt_q && !store_q;
            r1_bus_ready = done &&  gnt_q &&  store_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gnt_q       <= 1'b0;
            store_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rr_ptr      <= 1'b0;
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else if (state == IDLE) begin
            if (any_req) begin
                gnt_q   <= pick;
                store_q <= pick ? r1_store : r0_store;
                addr_q  <= pick ? r1_addr  : r0_addr;
                wdata_q <= pick ? r1_wdata : r0_wdata;
                wd_cnt  <= '0;
            end
        end else begin
            if (done) begin
                rr_ptr <= ~gnt_q;
            end else if (timeout_hit) begin
                rr_ptr      <= ~gnt_q;
                timeout_err <= 1'b1;
            end else if (wd_cnt != '1) begin
                wd_cnt <= wd_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Directed bench for cache_bus_arbiter: stimulus pushes expected grants and
// completions into queues, a negedge monitor pops and compares them.
module tb_cache_bus_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned LW = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          r0_valid, r0_store, r1_valid, r1_store;
    logic [AW-1:0] r0_addr, r1_addr;
    logic [LW-1:0] r0_wdata, r1_wdata;
    logic          r0_bus_valid, r0_bus_ready, r1_bus_valid, r1_bus_ready;
    logic [LW-1:0] r0_rdata, r1_rdata;
    logic          mem_valid, mem_store, mem_rready;
    logic [AW-1:0] mem_addr;
    logic [LW-1:0] mem_wdata;
    logic          mem_rvalid, mem_wready;
    logic [LW-1:0] mem_rdata;
    logic          timeout_err;

    cache_bus_arbiter #(
        .ADDR_WIDTH(AW),
        .LINE_WIDTH(LW),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .reset(reset),
        .r0_valid(r0_valid), .r0_store(r0_store), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_bus_valid(r0_bus_valid), .r0_bus_ready(r0_bus_ready), .r0_rdata(r0_rdata),
        .r1_valid(r1_valid), .r1_store(r1_store), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_bus_valid(r1_bus_valid), .r1_bus_ready(r1_bus_ready), .r1_rdata(r1_rdata),
        .mem_valid(mem_valid), .mem_store(mem_store), .mem_rready(mem_rready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_wready(mem_wready),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic          store;
        logic [LW-1:0] wdata;
    } grant_t;

    typedef struct {
        logic          req;
        logic          store;
        logic [LW-1:0] data;
    } cpl_t;

    grant_t gq[$];
    cpl_t   cq[$];
    int     checks = 0;
    int     errors = 0;
    logic   prev_mv = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_grant(input logic [AW-1:0] a, input logic s, input logic [LW-1:0] w);
        grant_t g;
        g.addr = a; g.store = s; g.wdata = w;
        gq.push_back(g);
    endtask

    task automatic push_cpl(input logic r, input logic s, input logic [LW-1:0] d);
        cpl_t c;
        c.req = r; c.store = s; c.data = d;
        cq.push_back(c);
    endtask

    always @(negedge clk) begin
        grant_t g;
        cpl_t   c;
        int     ncpl;
        if (!reset) begin
            if (mem_valid && !prev_mv) begin
                if (gq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_grant addr %h", mem_addr);
                end else begin
                    g = gq.pop_front();
                    check("grant_addr", 64'(mem_addr), 64'(g.addr));
                    check("grant_store", 64'(mem_store), 64'(g.store));
                    check("grant_wdata", mem_wdata, g.wdata);
                    check("grant_rready", 64'(mem_rready), 64'(!g.store));
                end
            end
            ncpl = int'(r0_bus_valid) + int'(r1_bus_valid) + int'(r0_bus_ready) + int'(r1_bus_ready);
            if (ncpl != 0) begin
                check("cpl_onehot", 64'(ncpl), 64'd1);
                if (cq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_cpl r0v %b r0r %b r1v %b r1r %b",
                             r0_bus_valid, r0_bus_ready, r1_bus_valid, r1_bus_ready);
                end else begin
                    c = cq.pop_front();
                    check("cpl_req", 64'(r1_bus_valid | r1_bus_ready), 64'(c.req));
                    check("cpl_store", 64'(r0_bus_ready | r1_bus_ready), 64'(c.store));
                    if (!c.store) check("cpl_rdata", c.req ? r1_rdata : r0_rdata, c.data);
                end
            end
        end
        prev_mv = mem_valid;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running expected finished");
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1'b1;
        r0_valid = 0; r0_store = 0; r0_addr = '0; r0_wdata = '0;
        r1_valid = 0; r1_store = 0; r1_addr = '0; r1_wdata = '0;
        mem_rvalid = 0; mem_wready = 0; mem_rdata = '0;
        step(); step();
        check("rst_mem_valid", 64'(mem_valid), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_store", 64'(mem_store), 64'd0);
        check("rst_timeout_err", 64'(timeout_err), 64'd0);
        reset = 1'b0;

        // Handshakes in IDLE are ignored.
        step();
        mem_rvalid = 1; mem_wready = 1;
        step(); step();
        mem_rvalid = 0; mem_wready = 0;
        check("idle_no_valid", 64'(mem_valid), 64'd0);

        // Single load from r0.
        r0_valid = 1; r0_addr = 32'h1000; r0_store = 0;
        push_grant(32'h1000, 0, '0);
        step();
        check("load_latency", 64'(mem_valid), 64'd1);
        step();
        step();
        mem_rvalid = 1; mem_rdata = 64'hA5A5_A5A5_A5A5_A5A5;
        push_cpl(0, 0, 64'hA5A5_A5A5_A5A5_A5A5);
        step();
        mem_rvalid = 0; r0_valid = 0;
        check("load_back_idle", 64'(mem_valid), 64'd0);

        // Simultaneous requests after reset: r0 first, then r1 store.
        reset = 1; step(); reset = 0;
        r0_valid = 1; r0_addr = 32'h40; r0_store = 0;
        r1_valid = 1; r1_addr = 32'h80; r1_store = 1; r1_wdata = 64'hDEAD_BEEF_CAFE_F00D;
        push_grant(32'h40, 0, '0);
        push_grant(32'h80, 1, 64'hDEAD_BEEF_CAFE_F00D);
        step();
        step();
        mem_wready = 1;
        step();
        mem_wready = 0; mem_rvalid = 1; mem_rdata = 64'h0123_4567_89AB_CDEF;
        push_cpl(0, 0, 64'h0123_4567_89AB_CDEF);
        step();
        mem_rvalid = 0; r0_valid = 0;
        step();
        check("store_mem_store", 64'(mem_store), 64'd1);
        mem_rvalid = 1;
        step();
        mem_rvalid = 0; mem_wready = 1;
        push_cpl(1, 1, '0);
        step();
        mem_wready = 0; r1_valid = 0; r1_store = 0;
        step();

        // r1 load ignores mem_wready, completes on mem_rvalid.
        r1_valid = 1; r1_addr = 32'h300; r1_store = 0;
        push_grant(32'h300, 0, 64'hDEAD_BEEF_CAFE_F00D);
        step();
        mem_wready = 1;
        step();
        mem_wready = 0;
        step();
        mem_rvalid = 1; mem_rdata = 64'h5555_AAAA_5555_AAAA;
        push_cpl(1, 0, 64'h5555_AAAA_5555_AAAA);
        step();
        mem_rvalid = 0; r1_valid = 0;
        step();

        // Round-robin fairness with both requesters held.
        reset = 1; step(); reset = 0;
        r0_valid = 1; r0_addr = 32'h100; r0_store = 0; r0_wdata = '0;
        r1_valid = 1; r1_addr = 32'h200; r1_store = 0; r1_wdata = '0;
        for (int k = 0; k < 6; k++) begin
            push_grant((k % 2) ? 32'h200 : 32'h100, 0, '0);
            n = 0;
            while (!mem_valid && n < 10) begin step(); n++; end
            if (!mem_valid) begin
                checks++; errors++;
                $display("FAIL rr_grant_wait got no grant expected grant %0d", k);
            end
            step(); step();
            mem_rvalid = 1; mem_rdata = 64'h0000_1111_0000_0000 | 64'(k);
            push_cpl(logic'(k % 2), 0, 64'h0000_1111_0000_0000 | 64'(k));
            step();
            mem_rvalid = 0;
        end
        r0_valid = 0; r1_valid = 0;
        step();

        // Watchdog: memory silent for r0 load.
        reset = 1; step(); reset = 0;
        r0_valid = 1; r0_addr = 32'h500; r0_store = 0;
        push_grant(32'h500, 0, '0);
        step();
        for (int i = 0; i < 8; i++) begin
            check("wd_busy", 64'(mem_valid), 64'd1);
            check("wd_no_err_yet", 64'(timeout_err), 64'd0);
            step();
        end
        check("wd_abort_idle", 64'(mem_valid), 64'd0);
        check("wd_err_set", 64'(timeout_err), 64'd1);
        r0_valid = 0;
        step(); step(); step();
        check("wd_err_sticky", 64'(timeout_err), 64'd1);
        reset = 1; step(); reset = 0;
        check("wd_err_reset", 64'(timeout_err), 64'd0);

        // Reset in the second BUSY cycle aborts silently.
        step();
        r0_valid = 1; r0_addr = 32'h600; r0_store = 0;
        push_grant(32'h600, 0, '0);
        step();
        step();
        reset = 1; r0_valid = 0;
        step();
        check("rstmid_mem_valid", 64'(mem_valid), 64'd0);
        check("rstmid_mem_addr", 64'(mem_addr), 64'd0);
        check("rstmid_mem_store", 64'(mem_store), 64'd0);
        check("rstmid_mem_rready", 64'(mem_rready), 64'd0);
        check("rstmid_mem_wdata", mem_wdata, 64'd0);
        reset = 0;
        r1_valid = 1; r1_addr = 32'h700; r1_store = 0;
        push_grant(32'h700, 0, '0);
        step();
        check("rstmid_r1_grant", 64'(mem_valid), 64'd1);
        step();
        mem_rvalid = 1; mem_rdata = 64'hFEED_0000_0000_0700;
        push_cpl(1, 0, 64'hFEED_0000_0000_0700);
        step();
        mem_rvalid = 0; r1_valid = 0;
        step(); step();

        check("grant_queue_empty", 64'(gq.size()), 64'd0);
        check("cpl_queue_empty", 64'(cq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_bus_arbiter.md
# cache_bus_arbiter

Two-requester arbiter that shares the single line-wide memory bus between the instruction cache (requester 0) and the data cache (requester 1). It sits between the caches' bus command ports and the memory model. It registers one command at a time and forwards it downstream. It routes the completion handshake and fill data back to the granted cache only. Round-robin priority prevents starvation, and a watchdog aborts transactions that never complete.

## Interface
- ADDR_WIDTH, 64, command address width
- LINE_WIDTH, 1024, cache line width in bits (DATA_WIDTH * 2**OFFSET_LENGTH)
- TIMEOUT_CYCLES, 1024, max cycles in BUSY before abort; 0 disables watchdog
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- r0_valid / r1_valid  in  1  requester command valid, held until completion
- r0_store / r1_store  in  1  1 = line writeback, 0 = line fill
- r0_addr / r1_addr  in  ADDR_WIDTH  line-aligned address
- r0_wdata / r1_wdata  in  LINE_WIDTH  writeback data
- r0_bus_valid / r1_bus_valid  out  1  fill complete for this requester
- r0_bus_ready / r1_bus_ready  out  1  writeback accepted for this requester
- r0_rdata / r1_rdata  out  LINE_WIDTH  fill data
- mem_valid  out  1  downstream command valid
- mem_store  out  1  downstream store
- mem_rready  out  1  downstream ready for fill data (= !mem_store while busy)
- mem_addr  out  ADDR_WIDTH  downstream address
- mem_wdata  out  LINE_WIDTH  downstream writeback data
- mem_rvalid  in  1  fill data valid
- mem_rdata  in  LINE_WIDTH  fill data
- mem_wready  in  1  writeback accepted
- timeout_err  out  1  sticky, watchdog fired

## Operation
- States: IDLE, BUSY.
- IDLE:
  - Neither valid: stay in IDLE.
  - Exactly one valid: grant that requester.
  - Both valid: grant the requester selected by rr_ptr.
  - On grant: latch gnt_id, store, addr and wdata into registers; go to BUSY.
- BUSY: mem_valid=1; mem_store, mem_addr and mem_wdata come from the latched registers; mem_rready=!store_q.
- Completion:
  - A load completes on mem_rvalid; a store completes on mem_wready.
  - In the completion cycle, assert r{gnt}_bus_valid (load) or r{gnt}_bus_ready (store) combinationally.
  - Set rr_ptr = ~gnt_id and go to IDLE.
  - mem_wready during a load and mem_rvalid during a store are ignored.
- r0_rdata = r1_rdata = mem_rdata at all times; only the bus_valid of the granted requester is ever asserted.
- Any mem_rvalid or mem_wready seen in IDLE is ignored.
- Requester inputs are not re-sampled while in BUSY; changes to them have no effect until the next IDLE.
- Watchdog:
  - Counter clears on grant and increments each BUSY cycle without completion.
  - If TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES: set timeout_err, go to IDLE, assert no completion to the requester, flip rr_ptr.
  - The counter saturates and never wraps.
  - timeout_err clears only on reset.

## Timing
- Reset values: state=IDLE, rr_ptr=0 (requester 0 first), all mem_* outputs 0, all r*_bus_valid/r*_bus_ready 0, timeout_err 0, latched registers 0.
- Reset asserted in BUSY aborts the transaction the next cycle with no completion pulse.
- Request latency: valid seen in IDLE at cycle N → mem_valid=1 at N+1.
- Turnaround: completion at cycle M → IDLE at M+1 → next grant's mem_valid at M+2. This gives a minimum of 2 cycles per transaction, with 1 IDLE cycle between transactions.
- Completion pulses are exactly 1 cycle and coincide with mem_rvalid/mem_wready.
- Same-cycle completion and timeout: completion wins; timeout_err is not set.
- A requester may re-assert valid in the cycle after its own completion (a fill followed by a writeback). If the other requester is also waiting, rr_ptr gives the grant to the other requester.

## Test plan
- Single load: r0 addr 0x1000, store 0. Expect mem_valid at N+1 with mem_addr 0x1000 and mem_rready=1. Drive mem_rvalid with rdata 0xA5..A5 at N+3 → r0_bus_valid=1 that cycle, r1_bus_valid=0, IDLE at N+4.
- Simultaneous after reset: r0 load 0x40 and r1 store 0x80 at cycle 1. Expect r0 granted first, then r1 with mem_store=1 and mem_wdata=r1_wdata; r1_bus_ready fires only on mem_wready.
- Round-robin fairness: r0 and r1 both held valid for 6 transactions, each completed 2 cycles after grant. Grants must alternate 0,1,0,1,0,1.
- Wrong-handshake filter: r1 load in BUSY, inject mem_wready=1 → no completion; later mem_rvalid → r1_bus_valid.
- Watchdog: TIMEOUT_CYCLES=8, r0 load, memory silent. Expect abort after 8 BUSY cycles; timeout_err=1 sticky, return to IDLE, r0_bus_valid never asserted. Reset clears timeout_err.
- Reset mid-transaction: reset in the 2nd BUSY cycle. Next cycle, all outputs are 0 and state is IDLE; a following r1-only request is granted.
